// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter:
// operation encodings and the carry-out helper.
package barrel_pkg;

    localparam logic [2:0] MODE_SRL = 3'b000;
    localparam logic [2:0] MODE_SRA = 3'b001;
    localparam logic [2:0] MODE_SLL = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // Operand is zero-extended to 64 bits; w is the live data width.
    function automatic logic carry_bit(
        input logic [63:0] d,
        input logic [6:0]  sh,
        input logic [6:0]  w,
        input logic [2:0]  mode
    );
        logic c;
        c = 1'b0;
        if (sh != 7'd0) begin
            case (mode)
                MODE_SRL, MODE_SRA, MODE_ROR: c = d[6'(sh - 7'd1)];
                MODE_SLL, MODE_ROL:           c = d[6'(w - sh)];
                default:                      c = 1'b0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One elastic pipeline stage of the barrel shifter: conditional shift by 2^K
// followed by the stage register with valid/load control.
module shift_stage #(
    parameter int WIDTH = 8,
    parameter int K     = 0,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SW-1:0]    prev_shamt,
    input  logic [2:0]       prev_mode,
    input  logic             prev_carry,
    input  logic             next_load,
    output logic             load,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output logic [SW-1:0]    shamt_q,
    output logic [2:0]       mode_q,
    output logic             carry_q,
    output logic             zero_q
);
    import barrel_pkg::*;

    localparam int S = 1 << K;

    logic [WIDTH-1:0] res;
    logic             valid_d;
    logic [WIDTH-1:0] data_d;
    logic [SW-1:0]    shamt_d;
    logic [2:0]       mode_d;
    logic             carry_d;
    logic             zero_d;

    always_comb begin
        res = prev_data;
        if (prev_shamt[K]) begin
            unique case (prev_mode)
                MODE_SRL: res = prev_data >> S;
                MODE_SRA: res = $signed(prev_data) >>> S;
                MODE_SLL: res = prev_data << S;
                MODE_ROL: res = (prev_data << S) | (prev_data >> (WIDTH - S));
                MODE_ROR: res = (prev_data >> S) | (prev_data << (WIDTH - S));
                default:  res = prev_data;
            endcase
        end
    end

    // Empty stages always load, so bubbles collapse.
    assign load = !valid_q || next_load;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (load) begin
            valid_d = prev_valid;
            if (prev_valid) begin
                data_d  = res;
                shamt_d = prev_shamt;
                mode_d  = prev_mode;
                carry_d = prev_carry;
                zero_d  = (res == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with valid/ready handshakes; stage k shifts by 2^k
// and the carry is resolved at acceptance and rides along with the beat.
module barrel_shifter_pipe #(
    parameter  int WIDTH  = 8,
    localparam int STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STAGES-1:0] in_shamt,
    input  logic [2:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_carry,
    output logic              out_zero
);
    import barrel_pkg::*;

    logic [STAGES:0]   v;
    logic [STAGES:0]   ld;
    logic [STAGES:0]   cy;
    logic [STAGES:1]   z;
    logic [WIDTH-1:0]  d  [STAGES+1];
    logic [STAGES-1:0] sh [STAGES+1];
    logic [2:0]        md [STAGES+1];
    logic              unused_tail;

    assign v[0]  = in_valid;
    assign d[0]  = in_data;
    assign sh[0] = in_shamt;
    assign md[0] = in_mode;
    assign cy[0] = carry_bit(64'(in_data), 7'(in_shamt), 7'(WIDTH), in_mode);

    assign ld[STAGES] = out_ready;
    assign in_ready   = ld[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k),
            .SW    (STAGES)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_valid (v[k]),
            .prev_data  (d[k]),
            .prev_shamt (sh[k]),
            .prev_mode  (md[k]),
            .prev_carry (cy[k]),
            .next_load  (ld[k+1]),
            .load       (ld[k]),
            .valid_q    (v[k+1]),
            .data_q     (d[k+1]),
            .shamt_q    (sh[k+1]),
            .mode_q     (md[k+1]),
            .carry_q    (cy[k+1]),
            .zero_q     (z[k+1])
        );
    end

    assign out_valid = v[STAGES];
    assign out_data  = d[STAGES];
    assign out_carry = cy[STAGES];
    assign out_zero  = z[STAGES];

    // Shift/mode of the final stage and early zero flags have no consumer.
    assign unused_tail = ^{sh[STAGES], md[STAGES], z};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: 8-bit and 32-bit instances,
// directed vectors, streaming, backpressure and mid-stream reset.
module tb_barrel_shifter_pipe;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        z;
        bit          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv8 = 1'b0, or8 = 1'b1;
    logic        ir8, ov8, oc8, oz8;
    logic [7:0]  id8 = '0, od8;
    logic [2:0]  is8 = '0, im8 = '0;

    logic        iv32 = 1'b0, or32 = 1'b1;
    logic        ir32, ov32, oc32, oz32;
    logic [31:0] id32 = '0, od32;
    logic [4:0]  is32 = '0;
    logic [2:0]  im32 = '0;

    exp_t q8[$];
    exp_t q32[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   n_acc8 = 0;

    barrel_shifter_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .in_shamt(is8), .in_mode(im8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8),
        .out_carry(oc8), .out_zero(oz8)
    );

    barrel_shifter_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv32), .in_ready(ir32), .in_data(id32),
        .in_shamt(is32), .in_mode(im32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32),
        .out_carry(oc32), .out_zero(oz32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic model8(input logic [7:0] d, input logic [2:0] sh,
                          input logic [2:0] m,
                          output logic [7:0] r, output logic c);
        logic [8:0]  rx;
        logic [15:0] lx;
        logic [15:0] dd;
        rx = {d, 1'b0} >> sh;
        lx = {8'h00, d} << sh;
        case (m)
            3'd0: begin r = d >> sh; c = rx[0]; end
            3'd1: begin r = 8'($signed(d) >>> sh); c = rx[0]; end
            3'd2: begin r = d << sh; c = lx[8]; end
            3'd3: begin dd = {d, d} << sh; r = dd[15:8]; c = lx[8]; end
            3'd4: begin dd = {d, d} >> sh; r = dd[7:0]; c = rx[0]; end
            default: begin r = d; c = 1'b0; end
        endcase
    endtask

    task automatic send8(input logic [7:0] d, input logic [2:0] sh,
                         input logic [2:0] m, input logic [7:0] ed,
                         input logic ec, input bit lat);
        exp_t e;
        bit   ok = 0;
        iv8 = 1'b1; id8 = d; is8 = sh; im8 = m;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ir8) begin
                ok = 1;
                e.d = {24'h0, ed}; e.c = ec; e.z = (ed == 8'h00);
                e.lat = lat; e.acc = cyc + 1;
                q8.push_back(e);
                n_acc8++;
            end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL accept8: in_ready stuck low, want 1");
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] d, input logic [4:0] sh,
                          input logic [2:0] m, input logic [31:0] ed,
                          input logic ec, input bit lat);
        exp_t e;
        bit   ok = 0;
        iv32 = 1'b1; id32 = d; is32 = sh; im32 = m;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ir32) begin
                ok = 1;
                e.d = ed; e.c = ec; e.z = (ed == 32'h0);
                e.lat = lat; e.acc = cyc + 1;
                q32.push_back(e);
            end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL accept32: in_ready stuck low, want 1");
        end
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while ((q8.size() != 0 || q32.size() != 0) && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (q8.size() != 0 || q32.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain: %0d/%0d results missing, want 0",
                     q8.size(), q32.size());
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL extra8: got result %0h, want none", od8);
            end else begin
                e = q8.pop_front();
                chk("data8", 32'(od8), e.d);
                chk("carry8", 32'(oc8), 32'(e.c));
                chk("zero8", 32'(oz8), 32'(e.z));
                if (e.lat) chk("lat8", 32'(cyc - e.acc), 32'd2);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov32 && or32) begin
            if (q32.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL extra32: got result %0h, want none", od32);
            end else begin
                e = q32.pop_front();
                chk("data32", od32, e.d);
                chk("carry32", 32'(oc32), 32'(e.c));
                chk("zero32", 32'(oz32), 32'(e.z));
                if (e.lat) chk("lat32", 32'(cyc - e.acc), 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d, r;
        logic [2:0] sh, m;
        logic       c;
        int         t0, a0;

        repeat (2) @(negedge clk);
        chk("rst_ov8", 32'(ov8), 32'd0);
        chk("rst_od8", 32'(od8), 32'd0);
        chk("rst_oc8", 32'(oc8), 32'd0);
        chk("rst_oz8", 32'(oz8), 32'd0);
        chk("rst_ir8", 32'(ir8), 32'd1);
        chk("rst_ov32", 32'(ov32), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        send8(8'h96, 3'd3, 3'd0, 8'h12, 1'b1, 1); drain();
        send8(8'h96, 3'd3, 3'd1, 8'hF2, 1'b1, 1); drain();
        send8(8'h96, 3'd3, 3'd2, 8'hB0, 1'b0, 1); drain();
        send8(8'h96, 3'd3, 3'd3, 8'hB4, 1'b0, 1); drain();
        send8(8'h96, 3'd3, 3'd4, 8'hD2, 1'b1, 1); drain();

        for (int i = 0; i < 8; i++)
            send8(8'h96, 3'd0, 3'(i), 8'h96, 1'b0, 0);
        send8(8'h01, 3'd1, 3'd0, 8'h00, 1'b1, 0);
        send8(8'h80, 3'd7, 3'd1, 8'hFF, 1'b0, 0);
        send8(8'h96, 3'd3, 3'd7, 8'h96, 1'b0, 0);
        send8(8'h96, 3'd5, 3'd5, 8'h96, 1'b0, 0);
        send8(8'h96, 3'd7, 3'd2, 8'h00, 1'b1, 0);
        send8(8'h01, 3'd1, 3'd4, 8'h80, 1'b1, 0);
        drain();

        send32(32'h8000_0001, 5'd31, 3'd4, 32'h0000_0003, 1'b0, 1);
        send32(32'h8000_0001, 5'd31, 3'd2, 32'h8000_0000, 1'b0, 1);
        drain();

        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom); sh = 3'($urandom); m = 3'($urandom_range(0, 7));
            model8(d, sh, m, r, c);
            send8(d, sh, m, r, c, 0);
        end
        chk("stream_cycles", 32'(cyc - t0), 32'd20);
        drain();

        or8 = 1'b0;
        a0 = n_acc8;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    d = 8'(8'h31 + 8'(i * 37)); sh = 3'(i + 1); m = 3'(i);
                    model8(d, sh, m, r, c);
                    send8(d, sh, m, r, c, 0);
                end
            end
            begin
                repeat (6) @(negedge clk);
                chk("held_beats", 32'(n_acc8 - a0), 32'd3);
                chk("full_ir8", 32'(ir8), 32'd0);
                chk("full_ov8", 32'(ov8), 32'd1);
                @(posedge clk); #1;
                or8 = 1'b1;
            end
        join
        drain();

        send8(8'hAA, 3'd1, 3'd0, 8'h55, 1'b0, 0);
        send8(8'h55, 3'd2, 3'd2, 8'h54, 1'b1, 0);
        rst = 1'b1;
        q8.delete();
        #1;
        chk("mid_ov8", 32'(ov8), 32'd0);
        chk("mid_od8", 32'(od8), 32'd0);
        chk("mid_oc8", 32'(oc8), 32'd0);
        chk("mid_oz8", 32'(oz8), 32'd0);
        chk("mid_ir8", 32'(ir8), 32'd1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_ir8", 32'(ir8), 32'd1);
        send8(8'h96, 3'd3, 3'd4, 8'hD2, 1'b1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
